// File: rtl/iterative_divider.sv
// iterative_divider
//   Multi-cycle restoring divider producing one quotient bit per cycle.
//   Signed (two's complement) and unsigned modes. Quotient truncates toward
//   zero; remainder takes the sign of the dividend. Latency from the accept
//   edge to out_valid is WORD_WIDTH+2 cycles for every operand value.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
//   both high. in_ready is high only while idle. Once out_valid rises it stays
//   high, with quotient/remainder/div_by_zero held stable, until out_ready is
//   seen. in_ready returns on the cycle after the output transfer.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   signed_mode         1 = signed operands (sampled on accept)
//   in_valid/in_ready   operand handshake
//   dividend, divisor   operands (sampled on accept)
//   out_valid/out_ready result handshake
//   quotient, remainder results
//   div_by_zero         divisor was zero (qualified by out_valid)
//   dbg_state           current FSM state, for observation only
module iterative_divider #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] dividend,
    input  logic [WORD_WIDTH-1:0] divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] quotient,
    output logic [WORD_WIDTH-1:0] remainder,
    output logic                  div_by_zero,
    output logic [2:0]            dbg_state
);

    localparam int W  = WORD_WIDTH;
    localparam int CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PREP   = 3'd1,
        S_DIVIDE = 3'd2,
        S_FIXUP  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            mode_q, mode_d;
    logic [W-1:0]    dvd_q, dvd_d;          // original dividend bits
    logic [W-1:0]    dvs_q, dvs_d;          // original divisor bits
    logic [W-1:0]    dvs_abs_q, dvs_abs_d;  // |divisor|, unsigned after PREP
    logic [W-1:0]    rem_q, rem_d;          // partial remainder
    logic [W-1:0]    quo_q, quo_d;          // |dividend| shifting out, quotient shifting in
    logic [CW-1:0]   count_q, count_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic [W-1:0]    quotient_q, quotient_d;
    logic [W-1:0]    remainder_q, remainder_d;
    logic            dbz_q, dbz_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;

    // Datapath for one restoring step.
    logic [W:0]      shifted;
    logic [W:0]      trial;
    logic            borrow;
    logic            dvd_neg;
    logic            dvs_neg;

    assign shifted = {rem_q, quo_q[W-1]};
    assign trial   = shifted - {1'b0, dvs_abs_q};
    // When shifted[W] is set the shifted value is >= 2^W and so exceeds any
    // divisor; the subtraction always succeeds and its low W bits are exact.
    assign borrow  = ~shifted[W] & trial[W];

    assign dvd_neg = mode_q & dvd_q[W-1];
    assign dvs_neg = mode_q & dvs_q[W-1];

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        dvs_abs_d   = dvs_abs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        count_d     = count_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mode_d     = signed_mode;
                    dvd_d      = dividend;
                    dvs_d      = divisor;
                    in_ready_d = 1'b0;
                    state_d    = S_PREP;
                end
            end
            S_PREP: begin
                // Negating the most negative value yields 2^(W-1) as an
                // unsigned number, which the unsigned datapath handles.
                quo_d     = dvd_neg ? (W'(0) - dvd_q) : dvd_q;
                dvs_abs_d = dvs_neg ? (W'(0) - dvs_q) : dvs_q;
                q_neg_d   = dvd_neg ^ dvs_neg;
                r_neg_d   = dvd_neg;
                rem_d     = '0;
                count_d   = CW'(W - 1);
                state_d   = S_DIVIDE;
            end
            S_DIVIDE: begin
                rem_d   = borrow ? shifted[W-1:0] : trial[W-1:0];
                quo_d   = {quo_q[W-2:0], ~borrow};
                count_d = count_q - CW'(1);
                if (count_q == '0) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                if (dvs_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = dvd_q;
                    dbz_d       = 1'b1;
                end else if (mode_q && dvd_q == {1'b1, {(W-1){1'b0}}} && dvs_q == '1) begin
                    quotient_d  = {1'b1, {(W-1){1'b0}}};
                    remainder_d = '0;
                    dbz_d       = 1'b0;
                end else begin
                    quotient_d  = q_neg_q ? (W'(0) - quo_q) : quo_q;
                    remainder_d = r_neg_q ? (W'(0) - rem_q) : rem_q;
                    dbz_d       = 1'b0;
                end
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            dvs_abs_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            count_q     <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            dvs_abs_q   <= dvs_abs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            count_q     <= count_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign dbg_state   = state_q;

endmodule
